// File: rtl/cgol_mon_pkg.sv
// Shared types and helpers for the cgol frame monitor.
package cgol_mon_pkg;

    localparam int unsigned N_DEF     = 8;
    localparam int unsigned N_MAX     = 32;
    localparam int unsigned IDX_MAX_W = 5;

    typedef enum logic {
        SYNC = 1'b0,
        SCAN = 1'b1
    } mon_state_e;

    typedef logic [N_DEF-1:0][N_DEF-1:0] frame_t;

    typedef struct packed {
        logic                 bad;
        logic [IDX_MAX_W-1:0] idx;
    } onehot_t;

    // One-hot to index; bad is set for zero or multi-hot vectors.
    function automatic onehot_t onehot_decode(input logic [N_MAX-1:0] vec);
        onehot_t r;
        r.idx = '0;
        for (int unsigned i = 0; i < N_MAX; i++) begin
            if (vec[i]) r.idx = IDX_MAX_W'(i);
        end
        r.bad = (vec == '0) || ((vec & (vec - N_MAX'(1))) != '0);
        return r;
    endfunction

endpackage

// File: rtl/cgol_popcount.sv
// Combinational population count of a flat bit vector.
module cgol_popcount #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0]         bits_i,
    output logic [$clog2(W+1)-1:0] count_o
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < W; i++) begin
            count_o = count_o + CNT_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/cgol_frame_monitor.sv
// Rebuilds cgol display frames from the row/col scan and reports per-frame statistics.
// Optional period-2 detection is enabled by defining CGOL_MON_PERIOD_EN.
module cgol_frame_monitor
    import cgol_mon_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned GEN_W = 16
) (
    input  logic                        ph1,
    input  logic                        reset_n,
    input  logic [N-1:0]                row,
    input  logic [N-1:0]                col,
    output logic                        frame_valid,
    output logic [$clog2(N*N+1)-1:0]    population,
    output logic [GEN_W-1:0]            generation,
    output logic                        still,
    output logic                        extinct,
    output logic                        seq_err
`ifdef CGOL_MON_PERIOD_EN
    ,
    output logic                        period2
`endif
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned POP_W = $clog2(N * N + 1);
    localparam logic [N-1:0]     ROW0     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    mon_state_e             state_q, state_d;
    logic [N-1:0]           prev_row_q;
    logic [IDX_W-1:0]       exp_idx_q, exp_idx_d, exp_c, store_idx_c;
    logic [N-1:0][N-1:0]    cur_q, last_q;
    logic [1:0]             hist_q;
    logic                   commit_pend_q;
    onehot_t                oh_c;
    logic                   capture_c, legal_c, resync_c;
    logic                   store_c, commit_c, err_c, still_c;
    logic [POP_W-1:0]       pop_c;

    assign capture_c = (row != prev_row_q) && (row != '0);
    assign oh_c      = onehot_decode(N_MAX'(row));
    assign exp_c     = (state_q == SCAN) ? exp_idx_q : '0;
    assign legal_c   = !oh_c.bad && (oh_c.idx == IDX_MAX_W'(exp_c));
    assign resync_c  = (row == ROW0);

    always_ff @(posedge ph1) begin
        if (!reset_n) state_q <= SYNC;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (capture_c) begin
            if (legal_c) state_d = (exp_c == LAST_IDX) ? SYNC : SCAN;
            else         state_d = resync_c ? SCAN : SYNC;
        end
    end

    // A bad capture that is exactly row 0 restarts the frame in the same cycle.
    always_comb begin
        store_c     = 1'b0;
        commit_c    = 1'b0;
        err_c       = 1'b0;
        store_idx_c = exp_c;
        exp_idx_d   = exp_c;
        if (capture_c) begin
            if (legal_c) begin
                store_c = 1'b1;
                if (exp_c == LAST_IDX) begin
                    commit_c  = 1'b1;
                    exp_idx_d = '0;
                end else begin
                    exp_idx_d = exp_c + IDX_W'(1);
                end
            end else begin
                err_c = 1'b1;
                if (resync_c) begin
                    store_c     = 1'b1;
                    store_idx_c = '0;
                    exp_idx_d   = IDX_W'(1);
                end else begin
                    exp_idx_d   = '0;
                end
            end
        end
    end

    cgol_popcount #(.W(N * N)) u_popcount (
        .bits_i  (cur_q),
        .count_o (pop_c)
    );

    assign still_c = (cur_q == last_q) && (hist_q != 2'd0);

`ifdef CGOL_MON_PERIOD_EN
    logic [N-1:0][N-1:0] last2_q;

    always_ff @(posedge ph1) begin
        if (!reset_n) begin
            last2_q <= '0;
            period2 <= 1'b0;
        end else if (commit_pend_q) begin
            last2_q <= last_q;
            period2 <= (cur_q == last2_q) && !still_c && (hist_q == 2'd2);
        end
    end
`endif

    // Commit is evaluated one cycle after the last row lands in cur_q.
    always_ff @(posedge ph1) begin
        if (!reset_n) begin
            prev_row_q    <= '0;
            exp_idx_q     <= '0;
            cur_q         <= '0;
            last_q        <= '0;
            hist_q        <= 2'd0;
            commit_pend_q <= 1'b0;
            frame_valid   <= 1'b0;
            seq_err       <= 1'b0;
            population    <= '0;
            generation    <= '0;
            still         <= 1'b0;
            extinct       <= 1'b0;
        end else begin
            prev_row_q    <= row;
            exp_idx_q     <= exp_idx_d;
            commit_pend_q <= commit_c;
            seq_err       <= err_c;
            frame_valid   <= commit_pend_q;
            if (store_c) cur_q[store_idx_c] <= col;
            if (commit_pend_q) begin
                population <= pop_c;
                still      <= still_c;
                extinct    <= (pop_c == '0);
                last_q     <= cur_q;
                if (hist_q != 2'd2)    hist_q     <= hist_q + 2'd1;
                if (generation != '1)  generation <= generation + GEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cgol_frame_monitor.sv
// Directed table-driven bench for cgol_frame_monitor.
module tb_cgol_frame_monitor;
    import cgol_mon_pkg::*;

    logic       ph1 = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] row = 8'h00;
    logic [7:0] col = 8'h00;
    logic       frame_valid;
    logic [6:0] population;
    logic [15:0] generation;
    logic       still, extinct, seq_err;
`ifdef CGOL_MON_PERIOD_EN
    logic       period2;
`endif

    cgol_frame_monitor #(.N(8), .GEN_W(16)) dut (
        .ph1         (ph1),
        .reset_n     (reset_n),
        .row         (row),
        .col         (col),
        .frame_valid (frame_valid),
        .population  (population),
        .generation  (generation),
        .still       (still),
        .extinct     (extinct),
        .seq_err     (seq_err)
`ifdef CGOL_MON_PERIOD_EN
        ,
        .period2     (period2)
`endif
    );

    always #5 ph1 = ~ph1;

    typedef struct {
        logic       rst_n;
        logic [7:0] row;
        logic [7:0] col;
        logic       fv;
        logic       err;
        logic       chk;
        int         pop;
        int         gen;
        logic       st;
        logic       ex;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   fv_cnt   = 0;
    int   err_cnt  = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic push(input logic rst_n, input logic [7:0] r, input logic [7:0] c,
                        input logic fv, input logic err, input logic chk,
                        input int pop, input int gen, input logic st, input logic ex);
        vec_t v;
        v.rst_n = rst_n; v.row = r; v.col = c; v.fv = fv; v.err = err; v.chk = chk;
        v.pop = pop; v.gen = gen; v.st = st; v.ex = ex;
        tbl.push_back(v);
    endtask

    task automatic push_frame(input frame_t f);
        for (int r = 0; r < 8; r++) push(1'b1, 8'(1 << r), f[r], 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic push_idle(input logic fv, input int pop, input int gen, input logic st, input logic ex);
        push(1'b1, 8'h00, 8'h00, fv, 1'b0, 1'b1, pop, gen, st, ex);
    endtask

    task automatic step();
        @(posedge ph1);
        #1;
        if (frame_valid) fv_cnt++;
        if (seq_err)     err_cnt++;
    endtask

`ifdef CGOL_MON_PERIOD_EN
    task automatic drive_frame(input frame_t f);
        for (int r = 0; r < 8; r++) begin
            row = 8'(1 << r);
            col = f[r];
            step();
        end
        row = 8'h00;
        col = 8'h00;
        step();
    endtask
`endif

    initial begin
        frame_t f_ff, f_sl, f_81, f_01, f_zero, f_a, f_b;
        int     idx;
        f_ff   = {8{8'hFF}};
        f_81   = {8{8'h81}};
        f_01   = {8{8'h01}};
        f_zero = '0;
        f_sl   = '0; f_sl[3] = 8'h18; f_sl[4] = 8'h18;
        f_a    = '0; f_a[3] = 8'h1C;
        f_b    = '0; f_b[2] = 8'h08; f_b[3] = 8'h08; f_b[4] = 8'h08;

        // reset state
        push(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        // clean full frame, then frame_valid drops after one cycle
        push_frame(f_ff);
        push_idle(1'b1, 64, 1, 1'b0, 1'b0);
        push_idle(1'b0, 64, 1, 1'b0, 1'b0);
        // still life: first differs from full frame, second matches
        push_frame(f_sl);
        push_idle(1'b1, 4, 2, 1'b0, 1'b0);
        push_frame(f_sl);
        push_idle(1'b1, 4, 3, 1'b1, 1'b0);
        // skipped row: error, outputs held, then recovery
        push(1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        push(1'b1, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        push(1'b1, 8'h08, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        push_idle(1'b0, 4, 3, 1'b1, 1'b0);
        push_frame(f_81);
        push_idle(1'b1, 16, 4, 1'b0, 1'b0);
        // non-one-hot row, then row 0 mid-scan resyncs with its own col
        push(1'b1, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        push(1'b1, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        push(1'b1, 8'h04, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        push(1'b1, 8'h03, 8'hFF, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        push(1'b1, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        push(1'b1, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        push(1'b1, 8'h01, 8'h0F, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int r = 1; r < 8; r++) push(1'b1, 8'(1 << r), 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        push_idle(1'b1, 4, 5, 1'b0, 1'b0);
        // back-to-back frames: first commit lands during the next frame's row 0
        push_frame(f_01);
        push_frame(f_01);
        idx = tbl.size() - 8;
        tbl[idx].fv = 1'b1; tbl[idx].chk = 1'b1; tbl[idx].pop = 8; tbl[idx].gen = 6;
        tbl[idx].st = 1'b0; tbl[idx].ex = 1'b0;
        push_idle(1'b1, 8, 7, 1'b1, 1'b0);
        // reset mid-frame, then first capture with k != 0 is an error
        for (int r = 0; r < 5; r++) push(1'b1, 8'(1 << r), 8'hAA, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        push(1'b0, 8'h20, 8'hAA, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        push(1'b1, 8'h40, 8'hAA, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
        push_idle(1'b0, 0, 0, 1'b0, 1'b0);
        push_frame(f_zero);
        push_idle(1'b1, 0, 1, 1'b0, 1'b1);

        foreach (tbl[i]) begin
            reset_n = tbl[i].rst_n;
            row     = tbl[i].row;
            col     = tbl[i].col;
            @(posedge ph1);
            #1;
            check($sformatf("v%0d frame_valid", i), 32'(frame_valid), 32'(tbl[i].fv));
            check($sformatf("v%0d seq_err", i), 32'(seq_err), 32'(tbl[i].err));
            if (tbl[i].chk) begin
                check($sformatf("v%0d population", i), 32'(population), 32'(tbl[i].pop));
                check($sformatf("v%0d generation", i), 32'(generation), 32'(tbl[i].gen));
                check($sformatf("v%0d still", i), 32'(still), 32'(tbl[i].st));
                check($sformatf("v%0d extinct", i), 32'(extinct), 32'(tbl[i].ex));
            end
        end

        // held rows with blanks between: one commit, no errors
        reset_n = 1'b1;
        fv_cnt  = 0;
        err_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            for (int h = 0; h < 3; h++) begin
                row = 8'(1 << k);
                col = 8'h00;
                step();
            end
            row = 8'h00;
            step();
        end
        for (int h = 0; h < 3; h++) step();
        check("held frame_valid count", 32'(fv_cnt), 32'd1);
        check("held seq_err count", 32'(err_cnt), 32'd0);
        check("held extinct", 32'(extinct), 32'd1);
        check("held still", 32'(still), 32'd1);
        check("held population", 32'(population), 32'd0);
        check("held generation", 32'(generation), 32'd2);

`ifdef CGOL_MON_PERIOD_EN
        // blinker: A, B, A -> third commit is period-2
        drive_frame(f_a);
        check("blink1 frame_valid", 32'(frame_valid), 32'd1);
        check("blink1 period2", 32'(period2), 32'd0);
        drive_frame(f_b);
        check("blink2 period2", 32'(period2), 32'd0);
        check("blink2 population", 32'(population), 32'd3);
        drive_frame(f_a);
        check("blink3 frame_valid", 32'(frame_valid), 32'd1);
        check("blink3 period2", 32'(period2), 32'd1);
        check("blink3 still", 32'(still), 32'd0);
        check("blink3 population", 32'(population), 32'd3);
        check("blink3 generation", 32'(generation), 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/cgol_frame_monitor.md
# cgol_frame_monitor

Downstream observer for the `cgol` core's display scan. It samples the one-hot `row` strobe and the `col` cell pattern and rebuilds each complete 8x8 generation frame. For every frame it reports the live-cell population, a generation count, still-life and extinction flags, and scan-sequence errors. It sits beside the LED matrix driver on the `row`/`col` bus and never drives the bus.

## Interface
Parameters:
- `N`, default 8: matrix dimension; equals the `row`/`col` width.
- `GEN_W`, default 16: generation counter width.

Ports:
- `ph1`, in, 1: the single clock; all state updates on its rising edge.
- `reset_n`, in, 1: synchronous, active-low reset, sampled on `ph1`.
- `row`, in, N: one-hot active-high row strobe from `cgol`; all-zero means blanked.
- `col`, in, N: active-high live-cell bits for the strobed row.
- `frame_valid`, out, 1: one-cycle pulse when a complete frame has been committed.
- `population`, out, $clog2(N*N+1): live cells in the last committed frame.
- `generation`, out, GEN_W: count of committed frames; saturates at all-ones.
- `still`, out, 1: last frame is identical to the previous committed frame.
- `extinct`, out, 1: last frame has `population` of 0.
- `seq_err`, out, 1: one-cycle pulse on a scan-sequence violation.

## Operation
- Reset (`reset_n`=0 at a `ph1` edge) clears all outputs, the frame buffers, `prev_row`, the expected index and the valid-history flag. Every output resets to 0. Reset mid-frame discards the partial frame.
- A row is captured on the first cycle it appears. The capture condition is `row != prev_row` and `row` != 0. `prev_row` is registered every cycle. A held row is not re-captured. A blank cycle sets `prev_row` = 0, so re-showing the same row after a blank counts as a new capture.
- On capture, the one-hot index `k` is checked against `exp_idx`. The FSM has two states: `SYNC`, where `exp_idx` is 0, and `SCAN`, where `exp_idx` is 1..N-1.
  - If `k` == `exp_idx`, `cur[k]` <= `col` and `exp_idx` advances. When k == N-1, the frame commits and the FSM returns to `SYNC`.
  - If `row` is not one-hot, or `k` != `exp_idx`: `seq_err` pulses, the partial frame is dropped and the FSM goes to `SYNC`. If the offending `row` is exactly `row[0]`, it is accepted as a fresh row 0 in the same cycle (`col` stored, `exp_idx` = 1).
  - The first capture out of reset in `SYNC` with k != 0 raises `seq_err` the same way.
- Commit actions:
  - `population` = popcount of all N rows of `cur`, including the `col` being written in this cycle.
  - `still` = (new frame == `last`) AND (`hist` >= 1).
  - `extinct` = (`population` == 0).
  - `last` <= new frame; `hist` increments, saturating at 2.
  - `generation` increments unless it is already all-ones.
- `population`, `still`, `extinct` and `generation` hold between commits.

## Timing
- Capture of row N-1 happens at edge t. `frame_valid` is high and the new `population`, `still`, `extinct` and `generation` are visible after edge t+1. The latency is 1 cycle, from one pipeline register after the popcount.
- `seq_err` goes high in the cycle after the violating capture edge and lasts exactly one cycle.
- A violation and a commit cannot coincide, because a commit requires a legal k == N-1.
- A `row` that changes every cycle is supported. The minimum frame is N consecutive cycles, and frames may be back-to-back.

## Configuration
- `CGOL_MON_PERIOD_EN` defined: adds a second history frame `last2` and the output `period2` (1 bit, resets to 0).
  - `period2` = (new frame == `last2`) AND NOT `still` AND (`hist` == 2). It is updated at each commit.
  - `last2` <= `last` at each commit.
- Undefined: no `last2` storage, and no `period2` port.

## Structure
- Package `cgol_mon_pkg`: the `N` default, the FSM state enum (`SYNC`, `SCAN`), the `frame_t` typedef (N x N bit array) and the function that converts one-hot to index with a not-one-hot flag.
- Sub-module `cgol_popcount`: combinational popcount of an N*N vector. The register stage sits in `cgol_frame_monitor`.

## Test plan
- **Clean frame:** reset, then `row` = 0x01, 0x02 … 0x80 on consecutive cycles with `col` = 0xFF for each. Expect `frame_valid` one cycle after row 0x80, `population` = 64, `generation` = 1, `still` = 0, `extinct` = 0.
- **Still life:** two identical frames, each with `col` = 0x18 on rows 3 and 4 and 0 elsewhere. The second commit gives `population` = 4, `still` = 1, `generation` = 2.
- **Extinction plus held rows:** each row is held 3 cycles with `col` = 0x00, and blank cycles sit between rows. Expect exactly one `frame_valid`, `extinct` = 1 and no `seq_err`.
- **Sequence error:** 0x01, 0x02, then 0x08. Expect `seq_err` one cycle later, no commit and `generation` unchanged. A following clean 0x01..0x80 frame commits normally.
- **Non-one-hot resync and reset:** `row` = 0x03 mid-frame gives `seq_err`. Then `row` = 0x01 is accepted as row 0. Asserting `reset_n` = 0 at row 5 clears all outputs to 0, and the next frame yields `generation` = 1.
- **Blinker (with `CGOL_MON_PERIOD_EN`):** alternating frames A (row 3, `col` = 0x1C) and B (`col` = 0x08 on rows 2, 3 and 4). The third commit gives `period2` = 1, `still` = 0, `population` = 3.
